// File: rtl/winograd_tile_arbiter.sv
// winograd_tile_arbiter
//   Shares one tile_controller (6x6 input tile, 3x3 kernel, 4x4 output tile)
//   among NUM_REQ requesters. Arbitration is round-robin. The winner's operands
//   are latched and the tile_controller start/done handshake is run. The result
//   comes back tagged with the requester index. A watchdog bounds the wait for
//   tc_done.
//
// Ports
//   clk, rst_n     clock (posedge) / asynchronous active-low reset
//   req_valid      per-requester pending flag, held until its req_ack
//   req_kernel     per-requester 3x3 kernel operands, [req][row][col]
//   req_tile       per-requester 6x6 input tile operands, [req][row][col]
//   req_ack        one-cycle pulse: operands of that requester were latched
//   rsp_valid      one-cycle pulse: rsp_id / rsp_result / rsp_timeout valid
//   rsp_id         requester index that owns the response
//   rsp_result     4x4 result tile, held until the next response
//   rsp_timeout    1 = watchdog abort; rsp_result is not updated
//   busy           high whenever a job is in flight
//   tc_start       one-cycle start pulse to the tile_controller
//   tc_kernel_in   latched kernel, stable for the whole job
//   tc_tile_in     latched tile, stable for the whole job
//   tc_result_out  result from the tile_controller
//   tc_done        level done from the tile_controller (may be stale-high)
module winograd_tile_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ-1:0][2:0][2:0][31:0]      req_kernel,
  input  logic [NUM_REQ-1:0][5:0][5:0][31:0]      req_tile,
  output logic [NUM_REQ-1:0]                      req_ack,
  output logic                                    rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]              rsp_id,
  output logic [3:0][3:0][31:0]                   rsp_result,
  output logic                                    rsp_timeout,
  output logic                                    busy,
  output logic                                    tc_start,
  output logic [2:0][2:0][31:0]                   tc_kernel_in,
  output logic [5:0][5:0][31:0]                   tc_tile_in,
  input  logic [3:0][3:0][31:0]                   tc_result_out,
  input  logic                                    tc_done
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_CLEAR,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_id;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_last;

  logic            any_req;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] scan_idx;

  // Search starts one past the last winner, so the most recent winner is
  // always considered last.
  always_comb begin
    any_req  = 1'b0;
    win_id   = '0;
    scan_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!any_req && req_valid[scan_idx]) begin
        any_req = 1'b1;
        win_id  = scan_idx;
      end
    end
  end

  assign wd_last = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      rr_ptr       <= ID_W'(NUM_REQ - 1);
      gnt_id       <= '0;
      wd_cnt       <= '0;
      req_ack      <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_timeout  <= 1'b0;
      tc_start     <= 1'b0;
      tc_kernel_in <= '0;
      tc_tile_in   <= '0;
    end else begin
      req_ack   <= '0;
      tc_start  <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            tc_kernel_in    <= req_kernel[win_id];
            tc_tile_in      <= req_tile[win_id];
            req_ack[win_id] <= 1'b1;
            gnt_id          <= win_id;
            rr_ptr          <= win_id;
            state           <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tc_start <= 1'b1;
          wd_cnt   <= '0;
          state    <= ST_WAIT_CLEAR;
        end
        // A done level left over from the previous job is ignored until it
        // has been seen low once.
        ST_WAIT_CLEAR: begin
          if (wd_last) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= gnt_id;
            rsp_timeout <= 1'b1;
            state       <= ST_RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (!tc_done) state <= ST_WAIT;
          end
        end
        // A done arriving on the last watchdog cycle still completes normally.
        ST_WAIT: begin
          if (tc_done) begin
            rsp_result  <= tc_result_out;
            rsp_valid   <= 1'b1;
            rsp_id      <= gnt_id;
            rsp_timeout <= 1'b0;
            state       <= ST_RESP;
          end else if (wd_last) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= gnt_id;
            rsp_timeout <= 1'b1;
            state       <= ST_RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
